// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg: shared datapath width, fetch defaults and fetch state encoding.
// Rev 1.0
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int BUF_DEPTH_DEFAULT = 2;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// fetch_fifo: in-order buffer with synchronous flush; head reads as zero when empty.
// Rev 1.0
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full buffer still accepts a push when its head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: credit-limited instruction fetch with in-order buffering and redirect drain.
// Rev 1.0
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(BUF_DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   target_aligned;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard_cnt;
  logic [CW-1:0]     buf_count;
  logic [CW-1:0]     pending_after_rsp;
  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_fire;
  logic              push;
  logic              pop;
  logic              buf_empty;
  logic [2*XLEN-1:0] head;

  assign target_aligned    = align_word(redirect_target);
  assign credit_used       = {1'b0, outstanding} + {1'b0, buf_count};
  // Requests are withheld in the redirect cycle so no wrong-path fetch is issued.
  assign imem_req_valid    = !rst && (state == RUN) && !redirect && (credit_used < CREDIT_MAX);
  assign imem_req_addr     = fetch_pc;
  assign req_fire          = imem_req_valid && imem_req_ready;
  // Responses with nothing in flight belong to requests abandoned by reset.
  assign rsp_fire          = imem_rsp_valid && (outstanding != '0);
  assign pending_after_rsp = outstanding - CW'(rsp_fire);
  assign push              = rsp_fire && (state == RUN) && !redirect;
  assign pop               = instr_valid && instr_ready;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign instr_valid = !buf_empty;
  assign instr_pc    = head[2*XLEN-1:XLEN];
  assign instr       = head[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (redirect && (pending_after_rsp != '0)) state_next = DRAIN;
      DRAIN:   if ((discard_cnt == '0) || (rsp_fire && (discard_cnt == CW'(1)))) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // rsp_pc tracks the address of the oldest live request, valid because responses return in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect) begin
        fetch_pc <= target_aligned;
        rsp_pc   <= target_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
      end
      if (state == RUN) begin
        if (redirect) discard_cnt <= pending_after_rsp;
      end else if (rsp_fire && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: randomized and directed scenarios checked against a queue-based fetch model.
// Rev 1.0
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  typedef struct packed { logic [31:0] pc; logic drop; } flight_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } entry_t;

  flight_t     inflight[$];
  entry_t      buffer[$];
  logic [31:0] memq[$];
  logic [31:0] m_pc;
  logic        m_req_valid, m_ivalid;
  logic [31:0] m_addr, m_instr, m_ipc;
  logic        s_req_valid;
  logic [31:0] s_addr;
  int          rsp_pct;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit draining();
    foreach (inflight[i]) if (inflight[i].drop) return 1'b1;
    return 1'b0;
  endfunction

  // Predict this cycle's outputs from the model and sample the DUT request.
  task automatic settle();
    @(negedge clk);
    m_req_valid = !rst && !draining() && !redirect && ((inflight.size() + buffer.size()) < DEPTH);
    m_addr      = m_pc;
    m_ivalid    = (buffer.size() > 0);
    m_instr     = m_ivalid ? buffer[0].data : 32'h0;
    m_ipc       = m_ivalid ? buffer[0].pc : 32'h0;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
  endtask

  // Apply the clock edge to the model and the memory, then pick the next memory response.
  task automatic advance();
    flight_t f, nf;
    entry_t  ne;
    bit      hs, got, pop;
    @(posedge clk);
    hs  = m_req_valid && imem_req_ready;
    pop = m_ivalid && instr_ready;
    got = imem_rsp_valid && (inflight.size() > 0);
    f   = '0;
    if (rst) begin
      inflight.delete();
      buffer.delete();
      memq.delete();
      m_pc = RESET_PC;
    end else begin
      if (s_req_valid && imem_req_ready) memq.push_back(s_addr);
      if (got) f = inflight.pop_front();
      if (redirect) begin
        buffer.delete();
        foreach (inflight[i]) inflight[i].drop = 1'b1;
        m_pc = {redirect_target[31:2], 2'b00};
      end else begin
        if (pop) buffer.delete(0);
        if (got && !f.drop) begin
          ne.pc = f.pc; ne.data = imem_rsp_data;
          buffer.push_back(ne);
        end
        if (hs) begin
          nf.pc = m_pc; nf.drop = 1'b0;
          inflight.push_back(nf);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
    if (memq.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = hash(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b0; instr_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rsp_pct = 0;
    repeat (2) begin settle(); advance(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    repeat (2) begin
      settle();
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: req_valid=%b instr_valid=%b instr=%h instr_pc=%h, required all 0",
                 imem_req_valid, instr_valid, instr, instr_pc);
      end
      advance();
    end
    rst = 1'b0;
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_request: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] got[$];
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_pct = 100;
    for (int c = 0; c < 14; c++) begin
      settle();
      checks++;
      if (imem_req_valid !== m_req_valid || (m_req_valid && imem_req_addr !== m_addr)) begin
        errors++;
        $display("FAIL stream_req c%0d: valid=%b addr=%h, expected valid=%b addr=%h", c, imem_req_valid, imem_req_addr, m_req_valid, m_addr);
      end
      checks++;
      if (instr_valid !== m_ivalid || instr !== m_instr || instr_pc !== m_ipc) begin
        errors++;
        $display("FAIL stream_instr c%0d: valid=%b instr=%h pc=%h, expected valid=%b instr=%h pc=%h",
                 c, instr_valid, instr, instr_pc, m_ivalid, m_instr, m_ipc);
      end
      if (instr_valid === 1'b1) got.push_back(instr_pc);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_order[%0d]: got %h, expected %h", i, (got.size() > i) ? got[i] : 32'hX, 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_pct = 100;
    n = 0;
    repeat (8) begin settle(); if (imem_req_valid && imem_req_ready) n++; advance(); end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL bp_requests: issued %0d, expected 2", n); end
    settle();
    checks++;
    if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr_pc !== 32'h0 || instr !== hash(32'h0)) begin
      errors++;
      $display("FAIL bp_full: instr_valid=%b req_valid=%b pc=%h instr=%h, expected 1 0 %h %h",
               instr_valid, imem_req_valid, instr_pc, instr, 32'h0, hash(32'h0));
    end
    advance();
    instr_ready = 1'b1;
    settle();
    advance();
    instr_ready = 1'b0;
    n = 0;
    repeat (6) begin settle(); if (imem_req_valid && imem_req_ready) n++; advance(); end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL bp_one_more: issued %0d, expected 1", n); end
    settle();
    checks++;
    if (instr_pc !== 32'h4 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_head: pc=%h req_valid=%b, expected pc=4 req_valid=0", instr_pc, imem_req_valid);
    end
    advance();
  endtask

  task automatic test_redirect_drain();
    bit seen;
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_pct = 0;
    repeat (2) begin settle(); advance(); end
    redirect = 1'b1; redirect_target = 32'h0000_0100; rsp_pct = 100;
    settle(); advance();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold[%0d]: req_valid=%b instr_valid=%b rsp_valid=%b, expected 0 0 1",
                 i, imem_req_valid, instr_valid, imem_rsp_valid);
      end
      advance();
    end
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL drain_resume: valid=%b addr=%h, expected valid=1 addr=00000100", imem_req_valid, imem_req_addr);
    end
    advance();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      settle();
      if (instr_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (instr_pc !== 32'h100) begin errors++; $display("FAIL drain_next_pc: got %h, expected 00000100", instr_pc); end
      end
      advance();
    end
    if (!seen) begin checks++; errors++; $display("FAIL drain_next_pc: no instruction within 6 cycles, expected pc 00000100"); end
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_pct = 0;
    settle(); advance();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = hash(memq.pop_front());
    redirect = 1'b1; redirect_target = 32'h0000_0243;
    settle(); advance();
    redirect = 1'b0; imem_req_ready = 1'b1;
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h240 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_redirect: req_valid=%b addr=%h instr_valid=%b, expected 1 00000240 0",
               imem_req_valid, imem_req_addr, instr_valid);
    end
    rsp_pct = 100;
    advance();
    settle(); advance();
    settle();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h240 || instr !== hash(32'h240)) begin
      errors++;
      $display("FAIL same_cycle_next: valid=%b pc=%h instr=%h, expected 1 00000240 %h", instr_valid, instr_pc, instr, hash(32'h240));
    end
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_pct = 100;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFF8;
    settle(); advance();
    redirect = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
      advance();
    end
    checks++;
    if (addrs.size() < 3 || addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %0d reqs first=%h second=%h third=%h, expected fffffff8 fffffffc 00000000",
               addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hX, (addrs.size() > 1) ? addrs[1] : 32'hX,
               (addrs.size() > 2) ? addrs[2] : 32'hX);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_pct = 100;
    repeat (6) begin settle(); advance(); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req_valid=%b instr_valid=%b instr=%h pc=%h, required all 0",
               imem_req_valid, instr_valid, instr, instr_pc);
    end
    rsp_pct = 0;
    settle(); advance();
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL post_reset_req: valid=%b addr=%h, expected valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    advance();
    imem_rsp_valid = 1'b0;
    settle();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL stray_response: instr_valid=%b, expected 0", instr_valid); end
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    rsp_pct = 60;
    for (int c = 0; c < 600; c++) begin
      imem_req_ready  = ($urandom_range(3) != 0);
      instr_ready     = ($urandom_range(2) != 0);
      redirect        = ($urandom_range(11) == 0);
      redirect_target = $urandom();
      settle();
      checks++;
      if (imem_req_valid !== m_req_valid || (m_req_valid && imem_req_addr !== m_addr)) begin
        errors++;
        $display("FAIL rand_req c%0d: valid=%b addr=%h, expected valid=%b addr=%h", c, imem_req_valid, imem_req_addr, m_req_valid, m_addr);
      end
      checks++;
      if (instr_valid !== m_ivalid || instr !== m_instr || instr_pc !== m_ipc) begin
        errors++;
        $display("FAIL rand_instr c%0d: valid=%b instr=%h pc=%h, expected valid=%b instr=%h pc=%h",
                 c, instr_valid, instr, instr_pc, m_ivalid, m_instr, m_ipc);
      end
      advance();
    end
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries; this is also the maximum of outstanding requests plus buffered entries.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 redirect  in  1  taken-branch/jump indication (PCsrc from decode).
REQ-006 redirect_target  in  32  next fetch address when redirect=1.
REQ-007 imem_req_valid  out  1  request to instruction memory.
REQ-008 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-009 imem_req_addr  out  32  word address of the request.
REQ-010 imem_rsp_valid  in  1  read data returning; responses are in order.
REQ-011 imem_rsp_data  in  32  instruction word.
REQ-012 instr_valid  out  1  instr/instr_pc hold a valid instruction for decode.
REQ-013 instr_ready  in  1  decode consumes the instruction this cycle.
REQ-014 instr  out  32  instruction word to decode.
REQ-015 instr_pc  out  32  address of instr.

Function
REQ-016 fetch_pc SHALL drive imem_req_addr; fetch_pc SHALL advance by 4 on each request handshake (valid and ready); the adder SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-017 imem_req_valid SHALL be 1 only when state=RUN and outstanding+buf_count < BUF_DEPTH (credit rule).
REQ-018 The outstanding counter SHALL increment on a request handshake and decrement on imem_rsp_valid; when both occur in one cycle it SHALL remain unchanged.
REQ-019 A response accepted in RUN SHALL be written to the buffer together with the PC of its request; instr_valid SHALL rise the cycle after the write (1-cycle rsp-to-decode latency).
REQ-020 Buffer order SHALL be FIFO; instr/instr_pc SHALL show the head entry; instr_valid = buffer not empty.
REQ-021 A push and a pop in the same cycle SHALL leave buf_count unchanged, including when the buffer is full.
REQ-022 States SHALL be RUN and DRAIN.
REQ-023 On redirect=1: the buffer SHALL flush; fetch_pc SHALL load redirect_target; discard_cnt SHALL load the outstanding count excluding any response arriving this cycle; the next state SHALL be DRAIN if that count is >0, else RUN.
REQ-024 A response arriving in the redirect cycle, or any response in DRAIN, SHALL be discarded; in DRAIN each response SHALL decrement discard_cnt, and the state SHALL become RUN when discard_cnt reaches 0.
REQ-025 In DRAIN, imem_req_valid SHALL be 0.
REQ-026 An instr handshake in the redirect cycle SHALL count as consumed (the branch itself); redirect SHALL take priority over all other buffer updates.
REQ-027 A redirect received in DRAIN SHALL reload fetch_pc and SHALL keep discard_cnt and the state unchanged.
REQ-028 Bits [1:0] of redirect_target SHALL be forced to 0.

Reset
REQ-029 While rst=1: fetch_pc=RESET_PC, state=RUN, buffer empty, outstanding=0, discard_cnt=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-030 The first request SHALL issue in the first clk edge after rst deasserts; reset mid-operation SHALL abandon all outstanding requests, and responses arriving after reset SHALL be ignored only when outstanding=0.

Structure
REQ-031 XLEN, RESET_PC default, BUF_DEPTH default and the state enum SHALL live in the shared package riscv_pkg.
REQ-032 The buffer SHALL be a sub-module fetch_fifo (parameterised depth, payload {pc,instr}, synchronous flush).

Verification
REQ-033 Reset, then imem_req_ready=1 with 1-cycle response and instr_ready=1 -> instr_pc sequence 0,4,8,C with one instruction per cycle after fill.
REQ-034 instr_ready=0 -> exactly 2 requests issue, buffer full, imem_req_valid=0; instr_ready=1 for 1 cycle -> exactly 1 new request.
REQ-035 Redirect to 32'h100 with 2 outstanding -> state DRAIN, 2 responses dropped, next instr_pc=32'h100.
REQ-036 Redirect and imem_rsp_valid in the same cycle, with outstanding=1 -> response dropped, state stays RUN, next request addr=target.
REQ-037 fetch_pc=32'hFFFF_FFFC -> following request addr=0.
REQ-038 Assert rst with 2 outstanding and a full buffer -> all outputs reach reset values immediately (asynchronous); after release, first request addr=RESET_PC.
